// File: rtl/pc_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_queue
// Purpose  : Owns the PC and prefetches {pc, inst} pairs into a DEPTH-entry
//            FIFO that feeds the decode stage over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en_i,
  input  logic                     jump_flag_i,
  input  logic [ADDR_W-1:0]        jump_addr_i,
  output logic [ADDR_W-1:0]        inst_addr_o,
  output logic                     inst_req_o,
  input  logic [INST_W-1:0]        inst_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [INST_W-1:0]        id_inst_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned       c_ptr_w      = $clog2(DEPTH);
  localparam int unsigned       c_cnt_w      = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
  localparam logic [ADDR_W-1:0] c_step       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(PC_STEP - 1);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
  logic [INST_W-1:0]  r_mem_inst [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_pop;
  logic               w_fetch;
  logic [ADDR_W-1:0]  w_jump_target;

  assign w_pop         = id_valid_o & id_ready_i;
  // A pop frees a slot in the same cycle, so a full queue can still fetch.
  assign w_fetch       = fetch_en_i & ~jump_flag_i & ((r_count < c_depth) | w_pop);
  assign w_jump_target = jump_addr_i & ~c_align_mask;

  assign inst_addr_o = r_pc;
  assign inst_req_o  = w_fetch;
  assign id_valid_o  = (r_count != '0);
  assign id_inst_o   = r_mem_inst[r_rd_ptr];
  assign id_pc_o     = r_mem_pc[r_rd_ptr];
  assign count_o     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
    end else if (jump_flag_i) begin
      // Redirect discards everything queued, including a coincident pop's slot.
      r_pc     <= w_jump_target;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_mem_pc[r_wr_ptr]   <= r_pc;
        r_mem_inst[r_wr_ptr] <= inst_i;
        r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
        r_pc                 <= r_pc + c_step;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
